// File: rtl/bus_pkg.sv
// Shared definitions for tristate system-bus slaves: FSM encoding, default widths
// and the local-address width helper.
package bus_pkg;

   localparam int DEFAULT_DATA_WIDTH = 16;
   localparam int DEFAULT_ADDR_WIDTH = 20;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_WAIT = 3'd1,
      RD_ACK  = 3'd2,
      WR_WAIT = 3'd3,
      WR_ACK  = 3'd4
   } bus_state_t;

   // Bits needed to index `size` words; never less than one so a one-word window still has an index.
   function automatic int addr_bits(input int size);
      int w;
      w = 1;
      while ((1 << w) < size)
         w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Window decoder for bus slaves: flags addresses in START_ADDRESS..START_ADDRESS+SIZE-1
// and returns the word offset inside that window.
module bus_addr_decode
   import bus_pkg::*;
#(
   parameter int          ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
   parameter int unsigned START_ADDRESS = 0,
   parameter int unsigned SIZE          = 1024,
   parameter int          LOCAL_WIDTH   = addr_bits(SIZE)
) (
   input  logic [ADDR_WIDTH-1:0]  bus_addr,
   output logic                   selected,
   output logic [LOCAL_WIDTH-1:0] local_addr
);

   // One extra bit keeps the window end from wrapping when the window touches the top of the map.
   localparam int              EW = ADDR_WIDTH + 1;
   localparam logic [EW-1:0]   LO = EW'(START_ADDRESS);
   localparam logic [EW-1:0]   HI = LO + EW'(SIZE) - EW'(1);

   logic [EW-1:0] addr_ext;

   assign addr_ext   = {1'b0, bus_addr};
   assign selected   = (addr_ext >= LO) && (addr_ext <= HI);
   assign local_addr = LOCAL_WIDTH'(bus_addr - LO[ADDR_WIDTH-1:0]);

endmodule

// File: rtl/bus_wait_memory.sv
// Data memory slave with programmable wait states and a bus_ready handshake on the tristate bus.
// Optional byte-lane writes via BUS_WAIT_MEMORY_BYTE_WRITE_EN (adds bus_be).
module bus_wait_memory
   import bus_pkg::*;
#(
   parameter int          DATA_WIDTH    = DEFAULT_DATA_WIDTH,
   parameter int          ADDR_WIDTH    = DEFAULT_ADDR_WIDTH,
   parameter int unsigned START_ADDRESS = 0,
   parameter int unsigned SIZE          = 1024,
   parameter int          WAIT_STATES   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   inout  wire  [DATA_WIDTH-1:0]   bus_data,
   input  logic [ADDR_WIDTH-1:0]   bus_addr,
   input  logic                    read,
   input  logic                    write,
`ifdef BUS_WAIT_MEMORY_BYTE_WRITE_EN
   input  logic [DATA_WIDTH/8-1:0] bus_be,
`endif
   inout  wire                     bus_ready
);

   localparam int LW = addr_bits(SIZE);

   bus_state_t            state, next_state;
   logic [3:0]            cnt;
   logic [LW-1:0]         addr_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] mem [SIZE];

   logic                  selected;
   logic [LW-1:0]         local_addr;
   logic                  rd_accept, wr_accept;

   logic                  mem_we;
   logic [LW-1:0]         mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
`ifdef BUS_WAIT_MEMORY_BYTE_WRITE_EN
   logic [DATA_WIDTH/8-1:0] be_q;
   logic [DATA_WIDTH/8-1:0] mem_be;
`endif

   bus_addr_decode #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .START_ADDRESS (START_ADDRESS),
      .SIZE          (SIZE),
      .LOCAL_WIDTH   (LW)
   ) u_decode (
      .bus_addr   (bus_addr),
      .selected   (selected),
      .local_addr (local_addr)
   );

   // Simultaneous read and write is a protocol error and is never accepted.
   assign rd_accept = selected && read && !write;
   assign wr_accept = selected && write && !read;

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (rd_accept)
               next_state = (WAIT_STATES == 0) ? RD_ACK : RD_WAIT;
            else if (wr_accept)
               next_state = (WAIT_STATES == 0) ? WR_ACK : WR_WAIT;
         end
         RD_WAIT: begin
            if (!read)
               next_state = IDLE;
            else if (cnt == 4'd1)
               next_state = RD_ACK;
         end
         RD_ACK:  next_state = IDLE;
         WR_WAIT: begin
            if (cnt == 4'd1)
               next_state = WR_ACK;
         end
         WR_ACK:  next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         addr_q  <= '0;
         rdata_q <= '0;
         wdata_q <= '0;
`ifdef BUS_WAIT_MEMORY_BYTE_WRITE_EN
         be_q    <= '0;
`endif
      end else begin
         state <= next_state;
         case (state)
            IDLE: begin
               if (rd_accept) begin
                  addr_q <= local_addr;
                  cnt    <= 4'(WAIT_STATES);
                  if (WAIT_STATES == 0)
                     rdata_q <= mem[local_addr];
               end else if (wr_accept) begin
                  addr_q  <= local_addr;
                  wdata_q <= bus_data;
                  cnt     <= 4'(WAIT_STATES);
`ifdef BUS_WAIT_MEMORY_BYTE_WRITE_EN
                  be_q    <= bus_be;
`endif
               end
            end
            RD_WAIT: begin
               cnt <= cnt - 4'd1;
               if (read && cnt == 4'd1)
                  rdata_q <= mem[addr_q];
            end
            WR_WAIT: cnt <= cnt - 4'd1;
            default: ;
         endcase
      end
   end

   // Zero-wait writes commit straight from the bus at accept; otherwise from the latched copy.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = addr_q;
      mem_wdata = wdata_q;
`ifdef BUS_WAIT_MEMORY_BYTE_WRITE_EN
      mem_be    = be_q;
`endif
      if (!rst) begin
         if (state == IDLE && wr_accept && WAIT_STATES == 0) begin
            mem_we    = 1'b1;
            mem_waddr = local_addr;
            mem_wdata = bus_data;
`ifdef BUS_WAIT_MEMORY_BYTE_WRITE_EN
            mem_be    = bus_be;
`endif
         end else if (state == WR_WAIT && cnt == 4'd1) begin
            mem_we = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
`ifdef BUS_WAIT_MEMORY_BYTE_WRITE_EN
         for (int b = 0; b < DATA_WIDTH / 8; b++)
            if (mem_be[b])
               mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
`else
         mem[mem_waddr] <= mem_wdata;
`endif
      end
   end

   assign bus_data  = (state == RD_ACK) ? rdata_q : {DATA_WIDTH{1'bz}};
   assign bus_ready = (state == RD_ACK || state == WR_ACK) ? 1'b1 : 1'bz;

endmodule
